tw_mult_stage: RTL and testbench

TW_MULT_STAGE -- requirements
Module: tw_mult_stage

---
 rtl/tw_mult_stage.sv | 172 +++++++++++++++++
 tb/tb_tw_mult_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tw_mult_stage.sv
// Twiddle multiply stage: complex sample times ROM twiddle, 3-cycle pipeline,
// rounding and saturation back to DW bits. Frame position comes from a 5-bit
// sample counter that also forms the twiddle ROM address.
module tw_mult_stage #(
    parameter int unsigned DW   = 22,
    parameter int unsigned FRAC = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    output logic [5:0]           tw_addr,
    input  logic signed [DW-1:0] tw_real,
    input  logic signed [DW-1:0] tw_imag,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_imag,
    output logic                 out_last
);

    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned SW    = 2 * DW + 1;
    localparam int          RND_I = 1 << (FRAC - 1);

    localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Frame sample counter
    logic [4:0] cnt_q, cnt_d;

    // S1: captured sample and twiddle
    logic signed [DW-1:0] s1_ar_q, s1_ar_d;
    logic signed [DW-1:0] s1_ai_q, s1_ai_d;
    logic signed [DW-1:0] s1_wr_q, s1_wr_d;
    logic signed [DW-1:0] s1_wi_q, s1_wi_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q, s1_last_d;

    // S2: partial products
    logic signed [PW-1:0] s2_rr_q, s2_rr_d;
    logic signed [PW-1:0] s2_ii_q, s2_ii_d;
    logic signed [PW-1:0] s2_ri_q, s2_ri_d;
    logic signed [PW-1:0] s2_ir_q, s2_ir_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_last_q, s2_last_d;

    // S3: output registers
    logic signed [DW-1:0] out_real_q, out_real_d;
    logic signed [DW-1:0] out_imag_q, out_imag_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    logic signed [SW-1:0] re_sum, im_sum;

    // Round half-up by 2^(FRAC-1), arithmetic shift, then clip to DW bits.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] r;
        r = x + SW'(RND_I);
        r = r >>> FRAC;
        if (r > SW'(OUT_MAX)) begin
            return OUT_MAX;
        end else if (r < SW'(OUT_MIN)) begin
            return OUT_MIN;
        end else begin
            return DW'(r);
        end
    endfunction

    // Twiddle ROM address: W=1 for the first half frame, then one step per sample
    assign tw_addr = {2'b10, cnt_q[4] ? cnt_q[3:0] : 4'b0000};

    // Counter and S1 capture; clr discards the presented sample
    always_comb begin
        cnt_d      = cnt_q;
        s1_ar_d    = s1_ar_q;
        s1_ai_d    = s1_ai_q;
        s1_wr_d    = s1_wr_q;
        s1_wi_d    = s1_wi_q;
        s1_valid_d = 1'b0;
        s1_last_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (in_valid) begin
            cnt_d      = cnt_q + 5'd1;
            s1_ar_d    = in_real;
            s1_ai_d    = in_imag;
            s1_wr_d    = tw_real;
            s1_wi_d    = tw_imag;
            s1_valid_d = 1'b1;
            s1_last_d  = (cnt_q == 5'd31);
        end
    end

    // S2 products, loaded only for valid S1 data
    always_comb begin
        s2_rr_d    = s2_rr_q;
        s2_ii_d    = s2_ii_q;
        s2_ri_d    = s2_ri_q;
        s2_ir_d    = s2_ir_q;
        s2_valid_d = s1_valid_q & ~clr;
        s2_last_d  = s1_valid_q & s1_last_q & ~clr;
        if (s1_valid_q) begin
            s2_rr_d = PW'(s1_ar_q) * PW'(s1_wr_q);
            s2_ii_d = PW'(s1_ai_q) * PW'(s1_wi_q);
            s2_ri_d = PW'(s1_ar_q) * PW'(s1_wi_q);
            s2_ir_d = PW'(s1_ai_q) * PW'(s1_wr_q);
        end
    end

    // S3 combine, round, saturate; data holds across bubbles
    always_comb begin
        re_sum      = SW'(s2_rr_q) - SW'(s2_ii_q);
        im_sum      = SW'(s2_ri_q) + SW'(s2_ir_q);
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        out_valid_d = s2_valid_q & ~clr;
        out_last_d  = s2_valid_q & s2_last_q & ~clr;
        if (s2_valid_q && !clr) begin
            out_real_d = round_sat(re_sum);
            out_imag_d = round_sat(im_sum);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            s1_ar_q     <= '0;
            s1_ai_q     <= '0;
            s1_wr_q     <= '0;
            s1_wi_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_rr_q     <= '0;
            s2_ii_q     <= '0;
            s2_ri_q     <= '0;
            s2_ir_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            s1_ar_q     <= s1_ar_d;
            s1_ai_q     <= s1_ai_d;
            s1_wr_q     <= s1_wr_d;
            s1_wi_q     <= s1_wi_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s2_rr_q     <= s2_rr_d;
            s2_ii_q     <= s2_ii_d;
            s2_ri_q     <= s2_ri_d;
            s2_ir_q     <= s2_ir_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_tw_mult_stage.sv
// Bench for tw_mult_stage: directed frame vectors plus bubble, clr and
// mid-frame reset sequences, checked every cycle against a cycle-indexed history.
module tb_tw_mult_stage;

    localparam int unsigned DW   = 22;
    localparam int unsigned FRAC = 6;
    localparam int          HN   = 2048;

    typedef logic signed [DW-1:0] smp_t;
    typedef struct {
        int ire;
        int iim;
        int ere;
        int eim;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    smp_t       in_real = '0;
    smp_t       in_imag = '0;
    logic [5:0] tw_addr;
    smp_t       tw_real, tw_imag;
    logic       out_valid, out_last;
    smp_t       out_real, out_imag;

    always #5 clk = ~clk;

    tw_mult_stage #(.DW(DW), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_real(in_real), .in_imag(in_imag), .tw_addr(tw_addr),
        .tw_real(tw_real), .tw_imag(tw_imag), .out_valid(out_valid),
        .out_real(out_real), .out_imag(out_imag), .out_last(out_last)
    );

    // round(64*cos(2*pi*j/32)) for j = 0..8
    int cos_tab [0:8] = '{64, 63, 59, 53, 45, 36, 24, 12, 0};

    function automatic int wj_re(input int j);
        if (j <= 8) return cos_tab[j];
        return -cos_tab[16 - j];
    endfunction

    function automatic int wj_im(input int j);
        return -cos_tab[(j <= 8) ? (8 - j) : (j - 8)];
    endfunction

    function automatic int idx_j(input int idx);
        return (idx < 16) ? 0 : idx - 16;
    endfunction

    // Twiddle ROM model: addresses 32..47 hold W^j
    always_comb begin
        tw_real = '0;
        tw_imag = '0;
        if (tw_addr[5:4] == 2'b10) begin
            tw_real = smp_t'(wj_re(int'(tw_addr[3:0])));
            tw_imag = smp_t'(wj_im(int'(tw_addr[3:0])));
        end
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   bcnt   = 0;
    bit   hv [0:HN-1];
    bit   hl [0:HN-1];
    bit   hr [0:HN-1];
    int   hre [0:HN-1];
    int   him [0:HN-1];
    int   hold_re = 0;
    int   hold_im = 0;
    vec_t tbl [0:63];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // One clock: check what the last edge produced, then drive the next inputs.
    task automatic cycle(input bit v, input bit c, input bit r,
                         input int ire, input int iim, input int ere, input int eim);
        @(negedge clk);
        if (cyc > 0) begin
            if (hr[cyc-1]) begin
                hold_re = 0;
                hold_im = 0;
            end
            if (cyc >= 3 && hv[cyc-3]) begin
                chk("out_valid", 64'(out_valid), 64'(1));
                chk("out_real", 64'(out_real), 64'(hre[cyc-3]));
                chk("out_imag", 64'(out_imag), 64'(him[cyc-3]));
                chk("out_last", 64'(out_last), 64'(hl[cyc-3]));
                hold_re = hre[cyc-3];
                hold_im = him[cyc-3];
            end else begin
                chk("out_valid_idle", 64'(out_valid), 64'(0));
                chk("out_last_idle", 64'(out_last), 64'(0));
                chk("hold_real", 64'(out_real), 64'(hold_re));
                chk("hold_imag", 64'(out_imag), 64'(hold_im));
            end
            chk("tw_addr", 64'(tw_addr), 64'(32 + idx_j(bcnt)));
        end
        rst_n    = r;
        clr      = c;
        in_valid = v;
        in_real  = smp_t'(ire);
        in_imag  = smp_t'(iim);
        hv[cyc]  = v && r && !c;
        hl[cyc]  = v && r && !c && (bcnt == 31);
        hre[cyc] = ere;
        him[cyc] = eim;
        hr[cyc]  = !r;
        if (!r || c) begin
            if (cyc >= 1) hv[cyc-1] = 1'b0;
            if (cyc >= 2) hv[cyc-2] = 1'b0;
            bcnt = 0;
        end else if (v) begin
            bcnt = (bcnt + 1) % 32;
        end
        cyc++;
    endtask

    task automatic send64();
        int j;
        j = idx_j(bcnt);
        cycle(1'b1, 1'b0, 1'b1, 64, 0, wj_re(j), wj_im(j));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t t;
        t.ire = a; t.iim = b; t.ere = c; t.eim = d;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < HN; i++) begin
            hv[i] = 1'b0; hl[i] = 1'b0; hr[i] = 1'b0; hre[i] = 0; him[i] = 0;
        end

        // Frame A: 64+0j everywhere -> output equals the twiddle
        for (int i = 0; i < 32; i++) tbl[i] = mk(64, 0, wj_re(idx_j(i)), wj_im(idx_j(i)));
        // Frame B: zeros plus hand-computed corner vectors
        for (int i = 32; i < 64; i++) tbl[i] = mk(0, 0, 0, 0);
        tbl[32 + 0]  = mk(100, -50, 100, -50);
        tbl[32 + 16] = mk(-1, 0, -1, 0);
        tbl[32 + 17] = mk(1, 1, 1, 1);
        tbl[32 + 20] = mk(2097151, 2097151, 2097151, 0);
        tbl[32 + 24] = mk(10, 3, 3, -10);
        tbl[32 + 25] = mk(2097151, 0, -393216, -2064383);
        tbl[32 + 26] = mk(2097151, 2097151, 1146879, -2097152);
        tbl[32 + 28] = mk(-64, 0, 45, 45);
        tbl[32 + 31] = mk(-2097152, 0, 2064384, 393216);

        // Reset
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

        // Two back-to-back frames from the table
        for (int i = 0; i < 64; i++)
            cycle(1'b1, 1'b0, 1'b1, tbl[i].ire, tbl[i].iim, tbl[i].ere, tbl[i].eim);
        idle(4);

        // Alternating valid: bubbles propagate, address steps only on accepts
        for (int i = 0; i < 20; i++) begin
            send64();
            idle(1);
        end
        idle(4);

        // clr after 10 samples, with a valid sample presented on the clr cycle
        for (int i = 0; i < 10; i++) send64();
        cycle(1'b1, 1'b1, 1'b1, 64, 0, 0, 0);
        for (int i = 0; i < 32; i++) send64();
        idle(4);

        // Mid-frame reset at cnt=20 with the pipeline full
        for (int i = 0; i < 40 && bcnt != 20; i++) send64();
        chk("pre_reset_cnt", 64'(bcnt), 64'(20));
        cycle(1'b1, 1'b1, 1'b0, 64, 0, 0, 0);
        for (int i = 0; i < 20; i++) send64();
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
